dot_accum: RTL and testbench
============================

DOT_ACCUM -- requirements
Module: dot_accum

Interface
REQ-001: Parameter CNT_W, default 8; width of the beat counter and of out_count.
REQ-002: clk  input  1  sole clock; all state updates on rising edge.
REQ-003: reset  input  1  synchronous, active-high reset.
REQ-004: in_valid  input  1  upstream dot-product result present on in_data.
REQ-005: in_ready  output  1  block can accept a beat this cycle.
REQ-006: in_data  input  27  dot-product result, float {sign[26], exp[25:18], mant[17:0]}.
REQ-007: in_last  input  1  qualifies the final beat of the current accumulation group.
REQ-008: out_valid  output  1  accumulated group result held on out_data.
REQ-009: out_ready  input  1  downstream accepts out_data this cycle.
REQ-010: out_data  output  27  accumulated sum, same float format as in_data.
REQ-011: out_count  output  CNT_W  number of beats summed into out_data.
REQ-012: busy  output  1  high while state is ACCUM or HOLD.

Function
REQ-013: An input beat is accepted when in_valid and in_ready are both high in the same cycle.
REQ-014: An output transfer occurs when out_valid and out_ready are both high in the same cycle.
REQ-015: The state machine has exactly three states: IDLE (no partial sum), ACCUM (partial sum held in acc), and HOLD (result presented).
REQ-016: Additions use one combinational FpAdd_c instance with operands acc and in_data; no other adder exists.
REQ-017: IDLE, beat accepted, in_last=0 -> acc<=in_data, cnt<=1, go to ACCUM.
REQ-018: IDLE, beat accepted, in_last=1 -> out_data<=in_data (no add), out_count<=1, go to HOLD.
REQ-019: ACCUM, beat accepted, in_last=0 -> acc<=FpAdd_c(acc,in_data), cnt<=cnt+1 saturating at all-ones, stay in ACCUM.
REQ-020: ACCUM, beat accepted, in_last=1 -> out_data<=FpAdd_c(acc,in_data), out_count<=cnt+1 saturating, go to HOLD.
REQ-021: HOLD asserts out_valid; out_data and out_count are stable until the output transfer occurs.
REQ-022: in_ready = (state != HOLD) || out_ready; the output register can therefore be emptied and refilled in the same cycle.
REQ-023: HOLD with a simultaneous output transfer and input beat -> the input beat is processed as from IDLE (REQ-017/018) in that same cycle.
REQ-024: HOLD, output transfer, no input beat -> go to IDLE.
REQ-025: Latency: out_valid rises in the cycle after the in_last beat is accepted; there are no other pipeline stages.
REQ-026: Throughput: one beat per cycle, sustained indefinitely while out_ready=1.
REQ-027: No cycle is idle between groups; beats with in_valid=0 leave all state unchanged.
REQ-028: The counter saturates and does not wrap; out_count shows all-ones for groups of 2^CNT_W-1 or more beats.
REQ-029: Sign, exponent, and rounding behaviour are exactly those of FpAdd_c; the block adds no normalisation or special-value handling.

Reset
REQ-030: While reset=1 at a clock edge: state<=IDLE, acc<=0, cnt<=0, out_data<=0, out_count<=0.
REQ-031: During reset, out_valid=0 and busy=0; in_ready=1 from the first cycle after reset deasserts.
REQ-032: Reset mid-group or in HOLD discards the partial sum or held result; a beat presented in the reset cycle is not accepted.

Verification
REQ-033: Group 1.0 (0x1FC0000), 2.0 (0x2000000), 3.0 (0x2020000, last), out_ready=1 -> one cycle later out_valid=1, out_data=0x2060000 (6.0), out_count=3.
REQ-034: Single beat 4.0 (0x2040000) with in_last=1 -> out_data=0x2040000, out_count=1, and FpAdd_c is bypassed.
REQ-035: out_ready=0 while HOLD -> in_ready=0, out_data stable for 5 cycles; raising out_ready with a new beat present -> transfer and acceptance in the same cycle.
REQ-036: Back-to-back groups {1.0, 1.0 last}, {2.0 last} with in_valid held high -> out_data 0x2000000 then 0x2000000 on consecutive transfers, with no bubble.
REQ-037: Reset asserted after 2 beats of a group -> busy=0; the next group 3.0 (last) yields 0x2020000 with out_count=1.
REQ-038: CNT_W=2, 5-beat group of 1.0 -> out_count=3 (saturated), out_data=FpAdd_c chain result 5.0 (0x2050000).

Source files
------------

// File: rtl/dot_accum.sv
// Streaming accumulator: sums groups of floating-point dot-product beats
// and presents each group total with its beat count on a valid/ready output.

module FpAdd_c (
  input  logic [26:0] i_a,
  input  logic [26:0] i_b,
  output logic [26:0] o_sum
);
  logic [26:0] w_big, w_sml;
  logic [7:0]  w_shamt;
  logic [19:0] w_m_big, w_m_sml, w_m_res;
  logic [17:0] w_norm;
  logic [4:0]  w_lz;
  logic        w_found, w_sub;

  always_comb begin
    w_big   = (i_b[25:0] > i_a[25:0]) ? i_b : i_a;
    w_sml   = (i_b[25:0] > i_a[25:0]) ? i_a : i_b;
    w_shamt = w_big[25:18] - w_sml[25:18];
    w_m_big = {1'b0, 1'b1, w_big[17:0]};
    w_m_sml = {1'b0, 1'b1, w_sml[17:0]} >> w_shamt;
    w_sub   = w_big[26] ^ w_sml[26];
    w_m_res = w_sub ? (w_m_big - w_m_sml) : (w_m_big + w_m_sml);

    w_lz    = 5'd0;
    w_found = 1'b0;
    for (int k = 18; k >= 0; k--) begin
      if (!w_found && w_m_res[k]) begin
        w_found = 1'b1;
        w_lz    = 5'(18 - k);
      end
    end
    w_norm = w_m_res[17:0] << w_lz;

    // A zero exponent is treated as a zero operand; everything else is normal.
    if (w_sml[25:18] == 8'd0) begin
      o_sum = w_big;
    end else if (w_m_res[19]) begin
      o_sum = {w_big[26], (w_big[25:18] == 8'hFF) ? 8'hFF : w_big[25:18] + 8'd1,
               w_m_res[18:1]};
    end else if (!w_found || (w_big[25:18] <= {3'b000, w_lz})) begin
      o_sum = 27'd0;
    end else begin
      o_sum = {w_big[26], w_big[25:18] - {3'b000, w_lz}, w_norm};
    end
  end
endmodule

module dot_accum #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [26:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [26:0]      out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             busy
);
  // state | meaning
  // IDLE  | no partial sum held
  // ACCUM | partial sum of the current group held in r_acc
  // HOLD  | group result presented on out_data until taken
  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;

  state_t           r_state;
  logic [26:0]      r_acc, r_out_data;
  logic [CNT_W-1:0] r_cnt, r_out_count;
  logic             r_out_valid, r_busy;
  logic [26:0]      w_sum;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_in_acc;

  FpAdd_c u_add (
    .i_a   (r_acc),
    .i_b   (in_data),
    .o_sum (w_sum)
  );

  assign in_ready  = !r_out_valid || out_ready;
  assign w_in_acc  = in_valid && in_ready;
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_data  <= '0;
      r_out_count <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else if (w_in_acc) begin
      if (r_state == S_ACCUM) begin
        if (in_last) begin
          r_out_data  <= w_sum;
          r_out_count <= w_cnt_inc;
          r_state     <= S_HOLD;
          r_out_valid <= 1'b1;
          r_busy      <= 1'b1;
        end else begin
          r_acc <= w_sum;
          r_cnt <= w_cnt_inc;
        end
      end else if (in_last) begin
        // Single-beat group (or first beat after a HOLD handoff): no add.
        r_out_data  <= in_data;
        r_out_count <= CNT_W'(1);
        r_state     <= S_HOLD;
        r_out_valid <= 1'b1;
        r_busy      <= 1'b1;
      end else begin
        r_acc       <= in_data;
        r_cnt       <= CNT_W'(1);
        r_state     <= S_ACCUM;
        r_out_valid <= 1'b0;
        r_busy      <= 1'b1;
      end
    end else if ((r_state == S_HOLD) && out_ready) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_count = r_out_count;
  assign busy      = r_busy;
endmodule

// File: tb/tb_dot_accum.sv
// Scoreboard bench for dot_accum: two instances (CNT_W=8 and CNT_W=2) share one stimulus stream.
module tb_dot_accum;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;
  logic [26:0] in_data = '0;

  logic        a_in_ready, a_out_valid, a_busy;
  logic [26:0] a_out_data;
  logic [7:0]  a_out_count;
  logic        b_in_ready, b_out_valid, b_busy;
  logic [26:0] b_out_data;
  logic [1:0]  b_out_count;

  int n_tests = 0;
  int n_fail  = 0;
  int or_mode = 1;

  typedef struct {logic [26:0] data; int n;} exp_t;
  exp_t sb_q[$];

  dot_accum #(.CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_data(a_out_data), .out_count(a_out_count), .busy(a_busy));

  dot_accum #(.CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_data(b_out_data), .out_count(b_out_count), .busy(b_busy));

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic real fp_dec(logic [26:0] f);
    real v;
    int  e;
    if (f[25:18] == 8'd0) return 0.0;
    v = 1.0 + real'(f[17:0]) / 262144.0;
    e = int'(f[25:18]) - 127;
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return f[26] ? -v : v;
  endfunction

  function automatic logic [26:0] fp_enc(real v);
    logic        s;
    real         a;
    int          e;
    logic [17:0] m;
    if (v == 0.0) return 27'd0;
    s = (v < 0.0);
    a = s ? -v : v;
    e = 127;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    m = 18'($rtoi((a - 1.0) * 262144.0));
    return {s, 8'(e), m};
  endfunction

  function automatic int sat(int n, int mx);
    return (n > mx) ? mx : n;
  endfunction

  // out_ready owner: 0 = low, 1 = high, otherwise random each cycle
  always @(posedge clk) begin
    #2;
    case (or_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Reference model: group sums in real arithmetic, pushes expected results
  bit  m_hold = 1'b0;
  int  m_n = 0;
  real m_sum = 0.0;
  always @(negedge clk) begin
    bit acc_b;
    check("out_valid_a", 32'(a_out_valid), 32'(m_hold));
    check("out_valid_b", 32'(b_out_valid), 32'(m_hold));
    check("busy_a", 32'(a_busy), 32'(m_hold || (m_n > 0)));
    check("busy_b", 32'(b_busy), 32'(m_hold || (m_n > 0)));
    check("in_ready_a", 32'(a_in_ready), 32'(!m_hold || out_ready));
    check("in_ready_b", 32'(b_in_ready), 32'(!m_hold || out_ready));
    if (reset) begin
      m_hold = 1'b0;
      m_n = 0;
      sb_q.delete();
    end else begin
      acc_b = in_valid && (!m_hold || out_ready);
      if (m_hold && out_ready) m_hold = 1'b0;
      if (acc_b) begin
        if (m_n == 0) m_sum = fp_dec(in_data);
        else          m_sum = m_sum + fp_dec(in_data);
        m_n++;
        if (in_last) begin
          sb_q.push_back('{data: fp_enc(m_sum), n: m_n});
          m_n = 0;
          m_hold = 1'b1;
        end
      end
    end
  end

  // Monitor: pops on each output transfer, checks stability while stalled
  bit          p_stall = 1'b0;
  logic [26:0] p_data;
  logic [7:0]  p_cnt;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      p_stall = 1'b0;
    end else begin
      if (p_stall) begin
        check("stall_data", 32'(a_out_data), 32'(p_data));
        check("stall_count", 32'(a_out_count), 32'(p_cnt));
      end
      if (a_out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_underflow: got output 0x%0h expected none", a_out_data);
        end else begin
          e = sb_q.pop_front();
          check("sb_data_a", 32'(a_out_data), 32'(e.data));
          check("sb_data_b", 32'(b_out_data), 32'(e.data));
          check("sb_count_a", 32'(a_out_count), 32'(sat(e.n, 255)));
          check("sb_count_b", 32'(b_out_count), 32'(sat(e.n, 3)));
        end
      end
      p_stall = a_out_valid && !out_ready;
      p_data  = a_out_data;
      p_cnt   = a_out_count;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the beat is taken.
  task automatic send(logic [26:0] d, logic l);
    int k = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    while (!(a_in_ready && !reset) && k < 50) begin
      k++;
      @(negedge clk);
    end
    check("send_timeout", 32'(k >= 50), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int len;
    int v;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_data", 32'(a_out_data), 32'd0);
    check("rst_count", 32'(a_out_count), 32'd0);
    check("rst_in_ready", 32'(a_in_ready), 32'd1);
    @(posedge clk);
    #1;

    // 1.0 + 2.0 + 3.0
    send(27'h1FC0000, 1'b0);
    send(27'h2000000, 1'b0);
    send(27'h2020000, 1'b1);
    in_valid = 1'b0;
    check("grp3_valid", 32'(a_out_valid), 32'd1);
    check("grp3_data", 32'(a_out_data), 32'h2060000);
    check("grp3_count", 32'(a_out_count), 32'd3);
    idle(2);

    // single beat bypass
    send(27'h2040000, 1'b1);
    in_valid = 1'b0;
    check("single_data", 32'(a_out_data), 32'h2040000);
    check("single_count", 32'(a_out_count), 32'd1);
    idle(2);

    // backpressure in HOLD, then simultaneous transfer and accept
    or_mode = 0;
    idle(1);
    send(27'h2000000, 1'b1);
    in_valid = 1'b1;
    in_data  = 27'h1FC0000;
    in_last  = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", 32'(a_in_ready), 32'd0);
      check("bp_data", 32'(a_out_data), 32'h2000000);
    end
    @(posedge clk);
    #1 or_mode = 1;
    @(negedge clk);
    check("bp_release_ready", 32'(a_in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_new_valid", 32'(a_out_valid), 32'd1);
    check("bp_new_data", 32'(a_out_data), 32'h1FC0000);
    idle(2);

    // back-to-back groups with no bubble
    send(27'h1FC0000, 1'b0);
    send(27'h1FC0000, 1'b1);
    check("b2b_g1_data", 32'(a_out_data), 32'h2000000);
    check("b2b_g1_count", 32'(a_out_count), 32'd2);
    send(27'h2000000, 1'b1);
    in_valid = 1'b0;
    check("b2b_g2_valid", 32'(a_out_valid), 32'd1);
    check("b2b_g2_data", 32'(a_out_data), 32'h2000000);
    check("b2b_g2_count", 32'(a_out_count), 32'd1);
    idle(2);

    // reset mid-group, with a beat offered during the reset cycle
    send(27'h1FC0000, 1'b0);
    send(27'h2000000, 1'b0);
    in_data = 27'h2040000;
    in_last = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    in_valid = 1'b0;
    check("rst_mid_busy", 32'(a_busy), 32'd0);
    check("rst_mid_valid", 32'(a_out_valid), 32'd0);
    send(27'h2020000, 1'b1);
    in_valid = 1'b0;
    check("rst_after_data", 32'(a_out_data), 32'h2020000);
    check("rst_after_count", 32'(a_out_count), 32'd1);
    idle(2);

    // saturation on the CNT_W=2 instance
    repeat (4) send(27'h1FC0000, 1'b0);
    send(27'h1FC0000, 1'b1);
    in_valid = 1'b0;
    check("sat_count_b", 32'(b_out_count), 32'd3);
    check("sat_data_b", 32'(b_out_data), 32'h2050000);
    check("sat_count_a", 32'(a_out_count), 32'd5);
    idle(2);

    // randomized groups, gaps, backpressure and occasional resets
    or_mode = 2;
    for (int g = 0; g < 250; g++) begin
      len = int'($urandom_range(1, 9));
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        if ($urandom_range(0, 60) == 0) begin
          reset = 1'b1;
          @(posedge clk);
          #1 reset = 1'b0;
        end
        v = int'($urandom_range(0, 600)) - 300;
        send(fp_enc(real'(v)), 1'(j == len - 1));
      end
    end
    or_mode = 1;
    idle(6);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
